rv_ctl: RTL and testbench

Multicycle control FSM for the RV32I subset datapath (`rv_dp`).
- Sequences fetch, decode, execute, memory and writeback by driving every datapath enable and mux select.
- Decodes `instr`, resolves branches from `zero`, and handshakes data memory through `dmem_re`, `dmem_we` and `dmem_rdy`.
- Supported instructions: R-type ALU, I-type ALU, LW, SW, BEQ, BNE and JAL. Any other opcode traps.

---
 rtl/rv_ctl.sv | 213 +++++++++++++++++++++
 tb/tb_rv_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_ctl.sv
// Multicycle control FSM for the RV32I-subset datapath rv_dp: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath enable and select.
package rv_ctl_pkg;
   // Select encodings shared with the datapath.
   localparam logic       PC_PLUS4  = 1'b0;
   localparam logic       PC_ALU    = 1'b1;
   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;
   localparam logic [1:0] IMM_L     = 2'd0;
   localparam logic [1:0] IMM_S     = 2'd1;
   localparam logic [1:0] IMM_B     = 2'd2;
   localparam logic [1:0] IMM_J     = 2'd3;
   localparam logic [1:0] ALUA_PCC  = 2'd0;
   localparam logic [1:0] ALUA_REG  = 2'd1;
   localparam logic [1:0] ALUB_IMM  = 2'd0;
   localparam logic [1:0] ALUB_REG  = 2'd1;
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

module rv_ctl
   import rv_ctl_pkg::*;
#(
   parameter int DPWIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DPWIDTH-1:0] instr,
   input  logic               zero,
   input  logic               dmem_rdy,
   output logic               pcsourse,
   output logic               pcwrite,
   output logic               pccen,
   output logic               irwrite,
   output logic               regwen,
   output logic               mdrwrite,
   output logic [1:0]         wbsel,
   output logic [1:0]         immsel,
   output logic [1:0]         asel,
   output logic [1:0]         bsel,
   output logic [3:0]         alusel,
   output logic               dmem_re,
   output logic               dmem_we,
   output logic               instret,
   output logic               illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXR, S_EXI, S_WB, S_MADDR,
      S_MRD, S_MWB, S_MWR, S_BR, S_JAL, S_TRAP
   } state_t;

   state_t state_q, state_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       unused_instr_bits;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7_b5 = instr[30];
   assign unused_instr_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

   // funct7[5] selects SUB only for register-register ops; shifts honour it for both forms.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
      case (f3)
         3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      pcsourse = PC_PLUS4;
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      regwen   = 1'b0;
      mdrwrite = 1'b0;
      wbsel    = WB_ALUOUT;
      immsel   = IMM_L;
      asel     = ALUA_PCC;
      bsel     = ALUB_IMM;
      alusel   = ALU_ADD;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      instret  = 1'b0;
      illegal  = 1'b0;

      case (state_q)
         S_FETCH: begin
            irwrite = 1'b1;
            pccen   = 1'b1;
            pcwrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // ALU computes pcc+imm here so BR/JAL find their target already in aluout.
            immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
            case (opcode)
               OP_R:             state_d = S_EXR;
               OP_I:             state_d = S_EXI;
               OP_LOAD, OP_STORE: state_d = S_MADDR;
               OP_BRANCH:        state_d = (funct3[2:1] == 2'b00) ? S_BR : S_TRAP;
               OP_JAL:           state_d = S_JAL;
               default:          state_d = S_TRAP;
            endcase
         end
         S_EXR: begin
            asel    = ALUA_REG;
            bsel    = ALUB_REG;
            alusel  = alu_decode(funct3, funct7_b5, 1'b1);
            state_d = S_WB;
         end
         S_EXI: begin
            asel    = ALUA_REG;
            alusel  = alu_decode(funct3, funct7_b5, 1'b0);
            state_d = S_WB;
         end
         S_WB: begin
            regwen  = 1'b1;
            instret = 1'b1;
            state_d = S_FETCH;
         end
         S_MADDR: begin
            asel    = ALUA_REG;
            immsel  = (opcode == OP_STORE) ? IMM_S : IMM_L;
            state_d = (opcode == OP_STORE) ? S_MWR : S_MRD;
         end
         S_MRD: begin
            asel     = ALUA_REG;
            dmem_re  = 1'b1;
            mdrwrite = dmem_rdy;
            if (dmem_rdy) state_d = S_MWB;
         end
         S_MWB: begin
            wbsel   = WB_MDR;
            regwen  = 1'b1;
            instret = 1'b1;
            state_d = S_FETCH;
         end
         S_MWR: begin
            asel    = ALUA_REG;
            immsel  = IMM_S;
            dmem_we = 1'b1;
            instret = dmem_rdy;
            if (dmem_rdy) state_d = S_FETCH;
         end
         S_BR: begin
            asel     = ALUA_REG;
            bsel     = ALUB_REG;
            alusel   = ALU_SUB;
            instret  = 1'b1;
            pcsourse = PC_ALU;
            pcwrite  = zero ^ funct3[0];
            state_d  = S_FETCH;
         end
         S_JAL: begin
            wbsel    = WB_PC;
            regwen   = 1'b1;
            pcwrite  = 1'b1;
            pcsourse = PC_ALU;
            instret  = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP:  illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase

      // Reset must silence the datapath immediately, not one edge later.
      if (rst) begin
         pcwrite  = 1'b0;
         pccen    = 1'b0;
         irwrite  = 1'b0;
         regwen   = 1'b0;
         mdrwrite = 1'b0;
         dmem_re  = 1'b0;
         dmem_we  = 1'b0;
         instret  = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_ctl.sv
// Self-checking bench for rv_ctl: per-cycle output expectations built from the
// instruction-level behaviour table, with randomized operands, flags and memory waits.
module tb_rv_ctl;
   import rv_ctl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        dmem_rdy = 1'b0;
   logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
   logic [1:0]  wbsel, immsel, asel, bsel;
   logic [3:0]  alusel;
   logic        dmem_re, dmem_we, instret, illegal;

   always #5 clk = ~clk;

   rv_ctl #(.DPWIDTH(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_rdy(dmem_rdy),
      .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
      .regwen(regwen), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel),
      .asel(asel), .bsel(bsel), .alusel(alusel), .dmem_re(dmem_re),
      .dmem_we(dmem_we), .instret(instret), .illegal(illegal)
   );

   typedef struct packed {
      logic       pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
      logic [1:0] wbsel, immsel, asel, bsel;
      logic [3:0] alusel;
      logic       dmem_re, dmem_we, instret, illegal;
   } obs_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        zero;
      obs_t        exp;
   } step_t;

   typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_BAD} kind_t;

   obs_t  obs;
   step_t plan[$];
   int    checks = 0;
   int    errors = 0;

   assign obs = {pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, wbsel, immsel,
                 asel, bsel, alusel, dmem_re, dmem_we, instret, illegal};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   function automatic obs_t dflt();
      obs_t o;
      o          = '0;
      o.asel     = ALUA_PCC;
      o.bsel     = ALUB_IMM;
      o.immsel   = IMM_L;
      o.alusel   = ALU_ADD;
      o.wbsel    = WB_ALUOUT;
      o.pcsourse = PC_PLUS4;
      return o;
   endfunction

   function automatic kind_t classify(input logic [31:0] ins);
      case (ins[6:0])
         OP_R:      return K_R;
         OP_I:      return K_I;
         OP_LOAD:   return K_LW;
         OP_STORE:  return K_SW;
         OP_BRANCH: return (ins[14:12] == 3'b000 || ins[14:12] == 3'b001) ? K_BR : K_BAD;
         OP_JAL:    return K_JAL;
         default:   return K_BAD;
      endcase
   endfunction

   function automatic logic [3:0] alu_expect(input logic [2:0] f3, input logic f7b5,
                                             input logic is_r);
      logic [3:0] tab [8];
      tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (f3 == 3'b000 && is_r && f7b5) return ALU_SUB;
      if (f3 == 3'b101 && f7b5)         return ALU_SRA;
      return tab[f3];
   endfunction

   task automatic push(input logic [31:0] ins, input logic r, input logic z, input obs_t e);
      step_t s;
      s.instr = ins;
      s.rdy   = r;
      s.zero  = z;
      s.exp   = e;
      plan.push_back(s);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction; 'extra' is the number of
   // dmem_rdy-low cycles for memory ops, or the trap cycles to observe for illegal ops.
   task automatic build_instr(input logic [31:0] ins, input int extra, input logic z);
      obs_t  e, addr;
      kind_t k;
      k = classify(ins);
      e = dflt(); e.irwrite = 1'b1; e.pccen = 1'b1; e.pcwrite = 1'b1;
      push($urandom, 1'($urandom), 1'($urandom), e);
      e = dflt(); e.immsel = (k == K_JAL) ? IMM_J : IMM_B;
      push(ins, 1'($urandom), 1'($urandom), e);
      case (k)
         K_R, K_I: begin
            e = dflt(); e.asel = ALUA_REG;
            e.bsel   = (k == K_R) ? ALUB_REG : ALUB_IMM;
            e.alusel = alu_expect(ins[14:12], ins[30], k == K_R);
            push(ins, 1'($urandom), 1'($urandom), e);
            e = dflt(); e.regwen = 1'b1; e.instret = 1'b1;
            push(ins, 1'($urandom), 1'($urandom), e);
         end
         K_LW, K_SW: begin
            addr = dflt(); addr.asel = ALUA_REG;
            addr.immsel = (k == K_SW) ? IMM_S : IMM_L;
            push(ins, 1'($urandom), 1'($urandom), addr);
            for (int i = 0; i < extra; i++) begin
               e = addr;
               if (k == K_LW) e.dmem_re = 1'b1; else e.dmem_we = 1'b1;
               push(ins, 1'b0, 1'($urandom), e);
            end
            e = addr;
            if (k == K_LW) begin e.dmem_re = 1'b1; e.mdrwrite = 1'b1; end
            else           begin e.dmem_we = 1'b1; e.instret  = 1'b1; end
            push(ins, 1'b1, 1'($urandom), e);
            if (k == K_LW) begin
               e = dflt(); e.wbsel = WB_MDR; e.regwen = 1'b1; e.instret = 1'b1;
               push(ins, 1'($urandom), 1'($urandom), e);
            end
         end
         K_BR: begin
            e = dflt(); e.asel = ALUA_REG; e.bsel = ALUB_REG; e.alusel = ALU_SUB;
            e.instret  = 1'b1;
            e.pcsourse = PC_ALU;
            e.pcwrite  = ins[12] ? !z : z;  // BEQ taken when equal, BNE when not
            push(ins, 1'($urandom), z, e);
         end
         K_JAL: begin
            e = dflt(); e.wbsel = WB_PC; e.regwen = 1'b1; e.pcwrite = 1'b1;
            e.pcsourse = PC_ALU; e.instret = 1'b1;
            push(ins, 1'($urandom), 1'($urandom), e);
         end
         default: begin
            for (int i = 0; i < extra; i++) begin
               e = dflt(); e.illegal = 1'b1;
               push(ins, 1'($urandom), 1'($urandom), e);
            end
         end
      endcase
   endtask

   // Plays queued steps: drive on the falling edge, sample 1 ns later.
   task automatic run_plan(input string name, input int limit);
      step_t s;
      int    n = 0;
      while (plan.size() > 0 && (limit < 0 || n < limit)) begin
         s = plan.pop_front();
         @(negedge clk);
         instr    = s.instr;
         zero     = s.zero;
         dmem_rdy = s.rdy;
         #1;
         checks++;
         if (obs !== s.exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, n, obs, s.exp);
         end
         n++;
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         instr    = $urandom;
         dmem_rdy = 1'b1;
         #1;
         checks++;
         if (obs !== dflt()) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, dflt());
         end
      end
      release_reset();
   endtask

   task automatic test_directed();
      build_instr(32'h002081B3, 0, 1'b0); run_plan("add", -1);
      build_instr(32'h0040A283, 2, 1'b0); run_plan("lw_wait2", -1);
      build_instr(32'h00208863, 0, 1'b1); run_plan("beq_equal", -1);
      build_instr(32'h00208863, 0, 1'b0); run_plan("beq_noteq", -1);
      build_instr(32'h00209863, 0, 1'b1); run_plan("bne_equal", -1);
      build_instr(32'h00209863, 0, 1'b0); run_plan("bne_noteq", -1);
      build_instr(32'h008000EF, 0, 1'b0); run_plan("jal", -1);
      build_instr(32'h4040D113, 0, 1'b0); run_plan("srai", -1);
      build_instr(32'h4000_8093, 0, 1'b0); run_plan("addi_bit30", -1);
      build_instr(32'h0011A423, 0, 1'b0); run_plan("sw", -1);
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [6:0]  ops [6];
      ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
      for (int i = 0; i < 150; i++) begin
         ins      = $urandom;
         ins[6:0] = ops[$urandom_range(0, 5)];
         if (ins[6:0] == OP_BRANCH) ins[14:12] = {2'b00, 1'($urandom)};
         build_instr(ins, $urandom_range(0, 3), 1'($urandom));
         run_plan("random", -1);
      end
   endtask

   task automatic test_trap();
      logic [31:0] bad [3];
      logic [31:0] ins;
      bad[0] = 32'h0000007F;
      bad[1] = 32'h0020A063;  // branch with funct3 010
      ins = $urandom;
      while (classify(ins) != K_BAD || ins[6:0] == OP_BRANCH) ins = $urandom;
      bad[2] = ins;
      for (int i = 0; i < 3; i++) begin
         build_instr(bad[i], (i == 0) ? 20 : 5, 1'b0);
         run_plan("trap", -1);
         #2 rst = 1'b1;
         #1;
         checks++;
         if (obs !== dflt()) begin
            errors++;
            $display("FAIL trap_reset_clear: got %h expected %h", obs, dflt());
         end
         release_reset();
      end
      build_instr(32'h002081B3, 0, 1'b0);
      run_plan("after_trap", -1);
   endtask

   task automatic test_sw_reset();
      build_instr(32'h0011A423, 5, 1'b0);
      run_plan("sw_wait", 5);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dmem_we !== 1'b0) begin
         errors++;
         $display("FAIL sw_async_reset_we: got %b expected 0", dmem_we);
      end
      checks++;
      if (obs !== dflt()) begin
         errors++;
         $display("FAIL sw_async_reset_outputs: got %h expected %h", obs, dflt());
      end
      plan.delete();
      release_reset();
      build_instr(32'h0040A283, 1, 1'b0);
      run_plan("after_sw_reset", -1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_trap();
      test_sw_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
